nibble_serial_adder_ctrl: RTL and testbench

Sequencing controller that adds two WIDTH-bit unsigned/two's-complement operands by time-sharing one existing `four_bit_adder` instance, one nibble per clock, least-significant nibble first. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. The carry is held in a register between nibbles. It is the building block for wide additions in the arithmetic datapath without replicating adder hardware.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 12 +
 rtl/nibble_serial_adder_ctrl_adder.sv | 15 +
 rtl/nibble_serial_adder_ctrl.sv | 132 +++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared arithmetic package for the nibble-serial adder controller.
package nibble_serial_adder_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : nibble_serial_adder_ctrl_pkg

// File: rtl/nibble_serial_adder_ctrl_adder.sv
// Existing combinational 4-bit ripple adder shared by the serial controller.
module four_bit_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    // Full 5-bit result of x + y + carry_in.
    always_comb begin
        {carry_out, sum} = 5'(x) + 5'(y) + 5'(carry_in);
    end

endmodule : four_bit_adder

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds two W-bit operands one nibble per clock, LSB nibble first, through a
// single shared four_bit_adder. Valid/ready handshakes on both sides.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter  int unsigned NIBBLES = 4,
    localparam int unsigned W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         busy
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t             state, state_nxt;
    logic [W-1:0]       a_r, a_nxt;
    logic [W-1:0]       b_r, b_nxt;
    logic               carry_r, carry_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [W-1:0]       sum_nxt;
    logic               cout_nxt;
    logic               ovf_nxt;

    logic [NIBBLE_W-1:0] add_x, add_y, add_sum;
    logic                add_cout;

    // Current nibble of each captured operand feeds the shared adder.
    assign add_x = a_r[NIBBLE_W*idx +: NIBBLE_W];
    assign add_y = b_r[NIBBLE_W*idx +: NIBBLE_W];

    four_bit_adder u_adder (
        .x         (add_x),
        .y         (add_y),
        .carry_in  (carry_r),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    // Next-state and datapath update; clear overrides every transition.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_r;
        b_nxt     = b_r;
        carry_nxt = carry_r;
        idx_nxt   = idx;
        sum_nxt   = sum;
        cout_nxt  = cout;
        ovf_nxt   = ovf;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    carry_nxt = cin;
                    idx_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                sum_nxt[NIBBLE_W*idx +: NIBBLE_W] = add_sum;
                carry_nxt = add_cout;
                if (idx == IDX_LAST) begin
                    cout_nxt  = add_cout;
                    ovf_nxt   = (a_r[W-1] == b_r[W-1]) && (add_sum[NIBBLE_W-1] != a_r[W-1]);
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (clear) begin
            state_nxt = IDLE;
            sum_nxt   = '0;
            cout_nxt  = 1'b0;
            ovf_nxt   = 1'b0;
            idx_nxt   = '0;
        end
    end

    // State and datapath registers; status flags registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            carry_r   <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            a_r       <= a_nxt;
            b_r       <= b_nxt;
            carry_r   <= carry_nxt;
            idx       <= idx_nxt;
            sum       <= sum_nxt;
            cout      <= cout_nxt;
            ovf       <= ovf_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt == RUN);
        end
    end

endmodule : nibble_serial_adder_ctrl

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed, table-driven bench for nibble_serial_adder_ctrl (NIBBLES=4).
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned NIB = 4;
    localparam int unsigned WW  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] a, b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] sum;
    logic          cout;
    logic          ovf;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vcin;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    vec_t vecs[8];

    nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid, returning the number of edges taken (-1 on timeout).
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    // One full transaction from accept to result handshake, with checks.
    task automatic run_op(input string name, input vec_t v);
        int lat;
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        a = v.va; b = v.vb; cin = v.vcin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = ~v.vcin;
        check({name, "_busy"}, 32'(busy), 32'd1);
        wait_valid(lat);
        check({name, "_latency"}, 32'(lat), 32'(NIB));
        check({name, "_sum"}, 32'(sum), 32'(v.esum));
        check({name, "_cout"}, 32'(cout), 32'(v.ecout));
        check({name, "_ovf"}, 32'(ovf), 32'(v.eovf));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({name, "_hold_sum"}, 32'(sum), 32'(v.esum));
    endtask

    initial begin
        int lat;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #12;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure in DONE while a second operand is offered.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'(NIB));
        a = 16'h0001; b = 16'h0002; cin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'h5555);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        check("bp_idle_busy", 32'(busy), 32'd0);
        tick();
        in_valid = 1'b0;
        check("bp_second_busy", 32'(busy), 32'd1);
        wait_valid(lat);
        check("bp_second_latency", 32'(lat), 32'(NIB));
        check("bp_second_sum", 32'(sum), 32'h0003);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset two cycles into RUN.
        a = 16'h1234; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        run_op("post_rst", vecs[4]);

        // Clear during RUN.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_run_in_ready", 32'(in_ready), 32'd1);
        check("clr_run_out_valid", 32'(out_valid), 32'd0);
        check("clr_run_busy", 32'(busy), 32'd0);
        check("clr_run_sum", 32'(sum), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("clr_run_no_valid", 32'(out_valid), 32'd0);
        end

        // Clear during DONE.
        a = 16'h7FFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        check("clr_done_pre_ovf", 32'(ovf), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_done_in_ready", 32'(in_ready), 32'd1);
        check("clr_done_out_valid", 32'(out_valid), 32'd0);
        check("clr_done_sum", 32'(sum), 32'd0);
        check("clr_done_ovf", 32'(ovf), 32'd0);

        run_op("after_clear", vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_nibble_serial_adder_ctrl
